// File: rtl/mlp_layer_avmm_ctrl.sv
// Avalon-MM slave front-end for one mlp_hidden_layer core: input vector registers,
// run control FSM with timeout and sticky status, result snapshots and latency counter.

// Sequential MAC core: one input element per cycle; neuron n weight for input i is (i - 2n - 1).
module mlp_hidden_layer #(
  parameter int unsigned IN_DIM      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned HIDDEN_SIZE = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [IN_DIM*DATA_W-1:0]      bus_in,
  output logic [HIDDEN_SIZE*ACC_W-1:0]  hidden_out_dbg_flat,
  output logic                          hidden_all_done
);
  localparam int unsigned IDX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

  logic [IN_DIM*DATA_W-1:0] x_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     busy_q;
  logic                     done_q;
  logic [ACC_W-1:0]         acc_q [HIDDEN_SIZE];
  logic [ACC_W-1:0]         term  [HIDDEN_SIZE];
  logic signed [DATA_W-1:0] x_cur;

  function automatic logic signed [ACC_W-1:0] weight(input int unsigned n,
                                                     input logic [IDX_W-1:0] i);
    int w;
    w = int'(i) - 2 * int'(n) - 1;
    return ACC_W'(w);
  endfunction

  always_comb begin
    x_cur = x_q[32'(idx_q) * DATA_W +: DATA_W];
    for (int unsigned n = 0; n < HIDDEN_SIZE; n++) begin
      term[n] = ACC_W'(ACC_W'(x_cur) * weight(n, idx_q));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int unsigned n = 0; n < HIDDEN_SIZE; n++) acc_q[n] <= '0;
    end else if (start) begin
      x_q    <= bus_in;
      idx_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      for (int unsigned n = 0; n < HIDDEN_SIZE; n++) acc_q[n] <= '0;
    end else if (busy_q) begin
      for (int unsigned n = 0; n < HIDDEN_SIZE; n++) acc_q[n] <= acc_q[n] + term[n];
      if (32'(idx_q) == IN_DIM - 1) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < HIDDEN_SIZE; n++) begin
      hidden_out_dbg_flat[n*ACC_W +: ACC_W] = acc_q[n];
    end
    hidden_all_done = done_q;
  end
endmodule

module mlp_layer_avmm_ctrl #(
  parameter int unsigned IN_DIM      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned HIDDEN_SIZE = 2,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W+1:0] avmm_address,
  input  logic [31:0]       avmm_writedata,
  input  logic              avmm_write,
  input  logic              avmm_read,
  output logic [31:0]       avmm_readdata,
  output logic              avmm_waitrequest,
  output logic              irq
);
  localparam int unsigned IN_BITS   = IN_DIM * DATA_W;
  localparam int unsigned IN_WORDS  = (IN_BITS + 31) / 32;
  localparam int unsigned LAST_BITS = IN_BITS - 32 * (IN_WORDS - 1);
  localparam logic [31:0] LAST_MASK = 32'((64'd1 << LAST_BITS) - 64'd1);
  localparam int unsigned W_CTRL    = 0;
  localparam int unsigned W_CYCLES  = 1;
  localparam int unsigned W_FREE    = 2;
  localparam int unsigned W_ID      = 3;
  localparam int unsigned W_IN      = 4;
  localparam int unsigned W_RES     = 16;
  localparam logic [31:0] ID_WORD   = {8'(IN_DIM), 8'(HIDDEN_SIZE), 8'(DATA_W), 8'(ACC_W)};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        start_q, start_d, start_dly_q;
  logic [31:0] cyc_q, cyc_d, cycles_q, cycles_d, free_q;
  logic        done_q, done_d, timeout_q, timeout_d;
  logic        overrun_q, overrun_d, irq_en_q, irq_en_d, irq_d;
  logic        snap_en, in_we;
  logic [31:0] in_words [IN_WORDS];
  logic [ACC_W-1:0] res_q [HIDDEN_SIZE];
  logic [31:0] res_ext [HIDDEN_SIZE];
  logic [32*IN_WORDS-1:0] in_flat;
  logic [HIDDEN_SIZE*ACC_W-1:0] core_out;
  logic        core_done, core_rst_n;
  logic [31:0] rd_data_c;
  int unsigned word_u;
  logic        ctrl_wr, in_wr, busy;
  logic        unused_addr_bits;

  function automatic logic [31:0] in_mask(input int unsigned k);
    return (k == IN_WORDS - 1) ? LAST_MASK : 32'hFFFF_FFFF;
  endfunction

  assign unused_addr_bits = ^avmm_address[1:0];
  assign avmm_waitrequest = 1'b0;
  assign core_rst_n       = ~reset;
  assign word_u           = 32'(avmm_address[ADDR_W+1:2]);
  assign ctrl_wr          = avmm_write && (word_u == W_CTRL);
  assign in_wr            = avmm_write && (word_u >= W_IN) && (word_u < W_IN + IN_WORDS);
  assign busy             = (state_q == S_RUN);

  always_comb begin
    for (int unsigned k = 0; k < IN_WORDS; k++) in_flat[32*k +: 32] = in_words[k];
  end

  mlp_hidden_layer #(
    .IN_DIM      (IN_DIM),
    .DATA_W      (DATA_W),
    .ACC_W       (ACC_W),
    .HIDDEN_SIZE (HIDDEN_SIZE)
  ) u_core (
    .clk                 (clk),
    .rst_n               (core_rst_n),
    .start               (start_q),
    .bus_in              (in_flat[IN_BITS-1:0]),
    .hidden_out_dbg_flat (core_out),
    .hidden_all_done     (core_done)
  );

  // Next-state and status update; a clear in the same CTRL write lands before any start.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    cyc_d     = cyc_q;
    cycles_d  = cycles_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    irq_en_d  = irq_en_q;
    snap_en   = 1'b0;
    in_we     = 1'b0;

    if (ctrl_wr) begin
      irq_en_d = avmm_writedata[2];
      if (avmm_writedata[1]) begin
        done_d    = 1'b0;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
      end
    end
    if (in_wr) begin
      if (busy) overrun_d = 1'b1;
      else      in_we     = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_wr && avmm_writedata[0]) begin
          state_d = S_RUN;
          start_d = 1'b1;
          cyc_d   = 32'd1;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (ctrl_wr && avmm_writedata[0]) overrun_d = 1'b1;
        // Core done may still be stale from a previous run during the first two cycles.
        if (core_done && !start_q && !start_dly_q) begin
          state_d  = S_DONE;
          snap_en  = 1'b1;
          cycles_d = cyc_q;
          done_d   = 1'b1;
        end else if (cyc_q == 32'(TIMEOUT)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    irq_d = done_d & irq_en_d;
  end

  always_comb begin
    for (int unsigned n = 0; n < HIDDEN_SIZE; n++) res_ext[n] = 32'(signed'(res_q[n]));
  end

  // Read mux; unmapped words return a recognisable marker.
  always_comb begin
    rd_data_c = 32'hDEAD_CAFE;
    if (word_u == W_CTRL)   rd_data_c = {27'd0, irq_en_q, overrun_q, timeout_q, done_q, busy};
    if (word_u == W_CYCLES) rd_data_c = cycles_q;
    if (word_u == W_FREE)   rd_data_c = free_q;
    if (word_u == W_ID)     rd_data_c = ID_WORD;
    for (int unsigned k = 0; k < IN_WORDS; k++) begin
      if (word_u == W_IN + k) rd_data_c = in_words[k];
    end
    for (int unsigned n = 0; n < HIDDEN_SIZE; n++) begin
      if (word_u == W_RES + n) rd_data_c = res_ext[n];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      start_dly_q   <= 1'b0;
      cyc_q         <= '0;
      cycles_q      <= '0;
      free_q        <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overrun_q     <= 1'b0;
      irq_en_q      <= 1'b0;
      irq           <= 1'b0;
      avmm_readdata <= '0;
      for (int unsigned k = 0; k < IN_WORDS; k++) in_words[k] <= '0;
      for (int unsigned n = 0; n < HIDDEN_SIZE; n++) res_q[n] <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      start_dly_q   <= start_q;
      cyc_q         <= cyc_d;
      cycles_q      <= cycles_d;
      free_q        <= free_q + 32'd1;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      overrun_q     <= overrun_d;
      irq_en_q      <= irq_en_d;
      irq           <= irq_d;
      avmm_readdata <= avmm_read ? rd_data_c : 32'd0;
      for (int unsigned k = 0; k < IN_WORDS; k++) begin
        if (in_we && (word_u == W_IN + k)) in_words[k] <= avmm_writedata & in_mask(k);
      end
      if (snap_en) begin
        for (int unsigned n = 0; n < HIDDEN_SIZE; n++) res_q[n] <= core_out[n*ACC_W +: ACC_W];
      end
    end
  end
endmodule

// File: tb/tb_mlp_layer_avmm_ctrl.sv
// Scoreboard bench: dut index 0 uses the default timeout, index 1 a timeout shorter than any run.
module tb_mlp_layer_avmm_ctrl;
  localparam int unsigned AW   = 5;
  localparam int unsigned TO_A = 1024;
  localparam int unsigned TO_B = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW+1:0] addr  [2];
  logic [31:0]   wdata [2];
  logic          wr    [2];
  logic          rd    [2];
  logic [31:0]   rdata [2];
  logic          wreq  [2];
  logic          irq   [2];

  mlp_layer_avmm_ctrl #(.TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .avmm_address(addr[0]), .avmm_writedata(wdata[0]),
    .avmm_write(wr[0]), .avmm_read(rd[0]), .avmm_readdata(rdata[0]),
    .avmm_waitrequest(wreq[0]), .irq(irq[0]));

  mlp_layer_avmm_ctrl #(.TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .avmm_address(addr[1]), .avmm_writedata(wdata[1]),
    .avmm_write(wr[1]), .avmm_read(rd[1]), .avmm_readdata(rdata[1]),
    .avmm_waitrequest(wreq[1]), .irq(irq[1]));

  int total = 0;
  int bad   = 0;
  int unsigned tb_cnt;

  // Reference state, one slot per dut
  logic [31:0] m_in  [2];
  logic [31:0] m_run_in [2];
  logic [31:0] m_cyc [2];
  logic [31:0] m_res [2][2];
  bit m_busy [2], m_done [2], m_to [2], m_ov [2], m_irq_en [2];

  logic [31:0] exp_q0[$], exp_q1[$];
  string       tag_q0[$], tag_q1[$];
  bit          rd_seen [2];

  always @(posedge clk) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= tb_cnt + 1;
    rd_seen[0] <= rd[0];
    rd_seen[1] <= rd[1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented read, otherwise readdata must idle at 0.
  always @(negedge clk) begin
    logic [31:0] e;
    string t;
    for (int d = 0; d < 2; d++) begin
      if (rd_seen[d]) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL dut%0d unexpected read data %08h", d, rdata[d]);
        end else begin
          if (d == 0) begin e = exp_q0.pop_front(); t = tag_q0.pop_front(); end
          else        begin e = exp_q1.pop_front(); t = tag_q1.pop_front(); end
          check(t, rdata[d], e);
          check($sformatf("dut%0d waitrequest", d), 32'(wreq[d]), 32'd0);
        end
      end else begin
        check($sformatf("dut%0d readdata idle", d), rdata[d], 32'd0);
      end
    end
  end

  function automatic logic [31:0] neuron(input logic [31:0] x, input int n);
    int s;
    logic signed [7:0] b;
    logic [15:0] tr;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      b = x[8*i +: 8];
      s += int'(b) * (i - 2*n - 1);
    end
    tr = 16'(s);
    return {{16{tr[15]}}, tr};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_in[d] = 0; m_run_in[d] = 0; m_cyc[d] = 0; m_res[d][0] = 0; m_res[d][1] = 0;
      m_busy[d] = 0; m_done[d] = 0; m_to[d] = 0; m_ov[d] = 0; m_irq_en[d] = 0;
    end
  endtask

  task automatic model_write(input int d, input int word, input logic [31:0] data);
    if (word == 0) begin
      if (data[1]) begin m_done[d] = 0; m_to[d] = 0; m_ov[d] = 0; end
      m_irq_en[d] = data[2];
      if (data[0]) begin
        if (m_busy[d]) m_ov[d] = 1;
        else begin m_busy[d] = 1; m_done[d] = 0; m_run_in[d] = m_in[d]; end
      end
    end else if (word == 4) begin
      if (m_busy[d]) m_ov[d] = 1;
      else m_in[d] = data;
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input int word);
    case (word)
      0:  return {27'd0, m_irq_en[d], m_ov[d], m_to[d], m_done[d], m_busy[d]};
      1:  return m_cyc[d];
      2:  return tb_cnt;
      3:  return 32'h0402_0810;
      4:  return m_in[d];
      16: return m_res[d][0];
      17: return m_res[d][1];
      default: return 32'hDEAD_CAFE;
    endcase
  endfunction

  task automatic push_exp(input int d, input int word);
    string t;
    t = $sformatf("dut%0d read word%0d", d, word);
    if (d == 0) begin exp_q0.push_back(model_read(d, word)); tag_q0.push_back(t); end
    else        begin exp_q1.push_back(model_read(d, word)); tag_q1.push_back(t); end
  endtask

  task automatic bus_write(input int d, input int word, input logic [31:0] data);
    addr[d] = 7'(word * 4); wdata[d] = data; wr[d] = 1'b1;
    model_write(d, word, data);
    @(posedge clk); #1;
    wr[d] = 1'b0;
  endtask

  task automatic bus_read(input int d, input int word);
    push_exp(d, word);
    addr[d] = 7'(word * 4); rd[d] = 1'b1;
    @(posedge clk); #1;
    rd[d] = 1'b0;
  endtask

  task automatic bus_rw(input int d, input int word, input logic [31:0] data);
    push_exp(d, word);
    model_write(d, word, data);
    addr[d] = 7'(word * 4); wdata[d] = data; rd[d] = 1'b1; wr[d] = 1'b1;
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for irq (irq_en must be set) and updates the model with the run outcome.
  task automatic wait_run(input int d, input int unsigned t0);
    int guard;
    int unsigned lat;
    guard = 0;
    while (!irq[d] && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!irq[d]) begin
      total++;
      bad++;
      $display("FAIL dut%0d run end: irq still 0 after %0d cycles, want 1", d, guard);
      return;
    end
    lat = tb_cnt - t0;
    m_busy[d] = 0;
    m_done[d] = 1;
    if (d == 1) begin
      check("timeout latency", lat, TO_B);
      m_to[d] = 1;
    end else begin
      check("run latency within timeout", 32'(lat <= TO_A), 32'd1);
      m_cyc[d] = lat;
      m_res[d][0] = neuron(m_run_in[d], 0);
      m_res[d][1] = neuron(m_run_in[d], 1);
    end
  endtask

  task automatic run_and_check(input int d, input logic [31:0] ctrl);
    int unsigned t0;
    bus_write(d, 0, ctrl);
    t0 = tb_cnt;
    bus_read(d, 0);
    wait_run(d, t0);
    bus_read(d, 16);
    bus_read(d, 17);
    bus_read(d, 1);
    bus_read(d, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    logic [31:0] x;
    int w;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; wr[d] = 1'b0; rd[d] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("irq after reset", 32'(irq[0]), 32'd0);

    // Reset values, ID, unmapped word, free counter
    bus_read(0, 0); bus_read(0, 1); bus_read(0, 16); bus_read(0, 17);
    bus_read(0, 3); bus_read(0, 9); bus_read(0, 2); bus_read(0, 2);
    bus_read(1, 0); bus_read(1, 3);

    // Directed first run
    bus_write(0, 4, 32'h0403_0201);
    bus_read(0, 4);
    run_and_check(0, 32'h5);

    // Randomized runs with interleaved unmapped / read-only accesses
    for (int it = 0; it < 8; it++) begin
      x = $urandom();
      bus_write(0, 4, x);
      bus_read(0, 4);
      w = ($urandom_range(0, 1) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(18, 31));
      bus_write(0, w, $urandom());
      bus_read(0, w);
      bus_write(0, $urandom_range(1, 3), $urandom());
      bus_read(0, 3);
      if (it % 3 == 0) begin
        bus_rw(0, 4, $urandom());
        bus_read(0, 4);
      end
      run_and_check(0, 32'h5);
      bus_read(0, 2);
    end

    // Timeout on the short-timeout instance; results and CYCLES stay at reset values
    bus_write(1, 4, $urandom());
    run_and_check(1, 32'h5);
    bus_read(1, 4);
    // Clear and start in one write restarts with timeout cleared
    run_and_check(1, 32'h7);

    // Overrun: input write and restart during RUN are ignored
    x = $urandom();
    bus_write(0, 4, x);
    bus_write(0, 0, 32'h5);
    t0 = tb_cnt;
    bus_write(0, 4, ~x);
    bus_write(0, 0, 32'h5);
    bus_read(0, 0);
    wait_run(0, t0);
    bus_read(0, 4); bus_read(0, 16); bus_read(0, 17); bus_read(0, 1); bus_read(0, 0);
    bus_write(0, 0, 32'h2);
    check("irq cleared by CTRL=2", 32'(irq[0]), 32'd0);
    bus_read(0, 0);

    // Reset mid-RUN
    bus_write(0, 4, $urandom());
    bus_write(0, 0, 32'h5);
    idle(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("irq a after mid-run reset", 32'(irq[0]), 32'd0);
    check("irq b after mid-run reset", 32'(irq[1]), 32'd0);
    bus_read(0, 2); bus_read(0, 0); bus_read(0, 1); bus_read(0, 4);
    bus_read(0, 16); bus_read(0, 17);
    idle(20);
    bus_read(0, 0); bus_read(0, 16);
    check("irq a stays low after reset", 32'(irq[0]), 32'd0);

    idle(3);
    check("scoreboard drained a", 32'(exp_q0.size()), 32'd0);
    check("scoreboard drained b", 32'(exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
